// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the mul/div unit
// Contents: op encodings (OP_*), FSM state encoding (ST_*), default WIDTH/CNT_W.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift/add-subtract datapath and HI/LO registers
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_load      : capture operand magnitudes (i_op, i_rs_val, i_rt_val)
//   i_load_dz   : divide-by-zero result straight into HI/LO
//   i_calc      : one multiply or divide iteration (i_is_div selects)
//   i_fix       : sign-correct and write HI/LO (i_neg_res, i_neg_rem)
//   i_cnt       : iterations still outstanding
//   o_calc_last : this CALC iteration is the last one
//   o_hi, o_lo  : architectural HI/LO
// Macro MULDIV_EARLY_TERM_EN: multiply ends once the remaining multiplier
// bits are zero; the skipped right shifts are applied in FIX.
module muldiv_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_load_dz,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_calc,
  input  logic             i_is_div,
  input  logic             i_fix,
  input  logic             i_neg_res,
  input  logic             i_neg_rem,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_calc_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // Multiply: upper half accumulates, lower half holds the multiplier.
  // Divide: upper half is the remainder, lower half dividend -> quotient.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_a;
  logic [WIDTH:0]     w_b;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~i_op[0];
  assign w_rs_mag = (w_signed && i_rs_val[WIDTH-1]) ? -i_rs_val : i_rs_val;
  assign w_rt_mag = (w_signed && i_rt_val[WIDTH-1]) ? -i_rt_val : i_rt_val;

  // Shared WIDTH+1 adder; for divide it subtracts and the carry-out means
  // "shifted remainder >= divisor".
  assign w_a   = i_is_div ? r_prod[2*WIDTH-1:WIDTH-1] : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
  assign w_b   = i_is_div ? ~{1'b0, r_opnd} : {1'b0, r_opnd};
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{(WIDTH+1){1'b0}}, i_is_div};

  always_comb begin
    w_prod_step = r_prod;
    if (i_is_div) begin
      if (w_sum[WIDTH+1])
        w_prod_step = {w_sum[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
      else
        w_prod_step = {r_prod[2*WIDTH-2:0], 1'b0};
    end else begin
      if (r_prod[0])
        w_prod_step = {w_sum[WIDTH:0], r_prod[WIDTH-1:1]};
      else
        w_prod_step = {1'b0, r_prod[2*WIDTH-1:1]};
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] w_mul_bits;
  // Multiplier bits not yet consumed sit below position i_cnt.
  assign w_mul_bits  = r_prod[WIDTH-1:0] & ~({WIDTH{1'b1}} << i_cnt);
  assign o_calc_last = (i_cnt == CNT_W'(1)) | (~i_is_div & ((w_mul_bits >> 1) == '0));
  assign w_prod_fix  = r_prod >> i_cnt;
`else
  assign o_calc_last = (i_cnt == CNT_W'(1));
  assign w_prod_fix  = r_prod;
`endif

  assign w_mul_res = i_neg_res ? -w_prod_fix : w_prod_fix;
  assign w_quo     = i_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem     = i_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_prod <= '0;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (i_load) begin
        if (i_op[1]) begin
          r_prod <= {{WIDTH{1'b0}}, w_rs_mag};
          r_opnd <= w_rt_mag;
        end else begin
          r_prod <= {{WIDTH{1'b0}}, w_rt_mag};
          r_opnd <= w_rs_mag;
        end
      end else if (i_calc) begin
        r_prod <= w_prod_step;
      end

      if (i_load_dz) begin
        r_hi <= i_rs_val;
        r_lo <= '1;
      end else if (i_fix) begin
        if (i_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_mul_res[2*WIDTH-1:WIDTH];
          r_lo <= w_mul_res[WIDTH-1:0];
        end
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - mul/div control FSM beside EX, owns HI/LO
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_start, i_op, i_rs_val, i_rt_val : op issue from EX
//   i_mf_req : MFHI/MFLO in ID/EX;  i_flush : squash in-flight op
//   o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
// Macro MULDIV_EARLY_TERM_EN: variable-latency multiply (see datapath).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_mf_req,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dz;

  logic             w_is_div;
  logic             w_signed;
  logic             w_dz;
  logic             w_accept;
  logic             w_load;
  logic             w_load_dz;
  logic             w_calc;
  logic             w_fix;
  logic             w_calc_last;

  assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_dz     = w_is_div && (i_rt_val == '0);

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_load_dz     = 1'b0;
    w_calc        = 1'b0;
    w_fix         = 1'b0;
    o_busy        = (r_state != ST_IDLE);
    o_done        = 1'b0;
    o_div_by_zero = 1'b0;
    o_stall       = (i_start | i_mf_req) & (r_state != ST_IDLE) & (r_state != ST_DONE);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts, so an op held by stall is taken without a bubble.
        if (r_state == ST_DONE) begin
          o_done        = 1'b1;
          o_div_by_zero = r_dz;
        end
        w_accept  = i_start & ~i_flush;
        w_load    = w_accept & ~w_dz;
        w_load_dz = w_accept & w_dz;
        if (w_accept)
          w_next = w_dz ? ST_DONE : ST_CALC;
        else
          w_next = ST_IDLE;
      end
      ST_CALC: begin
        w_calc = 1'b1;
        if (i_flush)
          w_next = ST_IDLE;
        else if (w_calc_last)
          w_next = ST_FIX;
      end
      ST_FIX: begin
        w_fix  = ~i_flush;
        w_next = i_flush ? ST_IDLE : ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt     <= CNT_W'(WIDTH);
        r_is_div  <= w_is_div;
        r_dz      <= w_dz;
        r_neg_res <= w_signed & (i_rs_val[WIDTH-1] ^ i_rt_val[WIDTH-1]);
        r_neg_rem <= w_signed & i_rs_val[WIDTH-1];
      end else if (w_calc) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_dz   (w_load_dz),
    .i_op        (i_op),
    .i_rs_val    (i_rs_val),
    .i_rt_val    (i_rt_val),
    .i_calc      (w_calc),
    .i_is_div    (r_is_div),
    .i_fix       (w_fix),
    .i_neg_res   (r_neg_res),
    .i_neg_rem   (r_neg_rem),
    .i_cnt       (r_cnt),
    .o_calc_last (w_calc_last),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed/scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_FULL = W + 2;
  localparam int LAT_MUL1 = EARLY ? 3 : LAT_FULL;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         mf_req;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_rs_val      (rs_val),
    .i_rt_val      (rt_val),
    .i_mf_req      (mf_req),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [64:0] sb [$];   // {div_by_zero, hi, lo}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] res(input logic d, input logic [31:0] h, input logic [31:0] l);
    return {d, h, l};
  endfunction

  // Reference behaviour from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  begin p = sa * sb_; return {1'b0, p}; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          sq = sa / sb_;
          sr = sa % sb_;
          return {1'b0, sr[31:0], sq[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic pop_cmp(input string tag);
    logic [64:0] e;
    chk({tag, "_pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      chk({tag, "_dz"}, 64'(dz), 64'(e[64]));
    end
  endtask

  // Entered on the negedge of the cycle after start was sampled (cycle 1).
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    pop_cmp(tag);
  endtask

  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [64:0] exp, input int lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, lat);
  endtask

  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;
  int          r_lat;
  int          n_done;
  logic [31:0] old_hi, old_lo;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = OP_MULT; rs_val = '0; rt_val = '0;
    mf_req = 1'b0; flush = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_flags", 64'({busy, stall, done, dz}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("mult_x1", OP_MULT, 32'h0fd76e10, 32'h1, res(0, 32'h0, 32'h0fd76e10), LAT_MUL1);
    issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, res(0, 32'hFFFFFFFE, 32'h1), LAT_FULL);
    issue("mult_min", OP_MULT, 32'h80000000, 32'h80000000, res(0, 32'h40000000, 32'h0), LAT_FULL);
    issue("div_neg7", OP_DIV, 32'hFFFFFFF9, 32'h2, res(0, 32'hFFFFFFFF, 32'hFFFFFFFD), LAT_FULL);
    issue("divu_zero", OP_DIVU, 32'h0fd76e10, 32'h0, res(1, 32'h0fd76e10, 32'hFFFFFFFF), 1);
    issue("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, res(0, 32'h0, 32'h80000000), LAT_FULL);
    issue("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h7, res(0, 32'hFFFFFFFF, 32'hFFFFFFEB), LAT_FULL);

    for (int k = 0; k < 6; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (k == 2) ? 32'h0 : ((k == 4) ? 32'($urandom_range(1, 15)) : $urandom);
      if (k == 1) r_op = OP_DIV;
      r_lat = (r_op[1] && r_b == 0) ? 1 : ((r_op[1] || !EARLY) ? LAT_FULL : 0);
      issue("rnd", r_op, r_a, r_b, model(r_op, r_a, r_b), r_lat);
    end

    // Held start + MF while busy: stall until DONE, then taken without a bubble.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    sb.push_back(res(0, 32'd0, 32'd15));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7; mf_req = 1'b1;
    sb.push_back(res(0, 32'd2, 32'd14));
    #1;
    chk("stall_held", 64'(stall), 64'd1);
    @(negedge clk);
    while (done !== 1'b1 && stall === 1'b1) @(negedge clk);
    chk("first_done", 64'(done), 64'd1);
    chk("stall_in_done", 64'(stall), 64'd0);
    pop_cmp("first");
    mf_req = 1'b0;
    @(negedge clk);
    chk("second_busy", 64'(busy), 64'd1);
    chk("second_no_done", 64'(done), 64'd0);
    start = 1'b0;
    wait_done("second", LAT_FULL);

    // start + MF in IDLE: op accepted, MF sees the old HI/LO without stall.
    @(negedge clk);
    start = 1'b1; mf_req = 1'b1; op = OP_MULTU; rs_val = 32'd7; rt_val = 32'd9;
    sb.push_back(res(0, 32'd0, 32'd63));
    #1;
    chk("idle_mf_stall", 64'(stall), 64'd0);
    chk("idle_mf_old_lo", 64'(lo), 64'd14);
    @(negedge clk);
    start = 1'b0; mf_req = 1'b0;
    wait_done("mf_op", LAT_FULL);

    // Flush at CALC cycle 10: back to IDLE, HI/LO kept, no done.
    old_hi = hi; old_lo = lo;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_val = 32'd5; rt_val = 32'h80000006;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("flush_no_done", 64'(n_done), 64'd0);
    chk("flush_hi", 64'(hi), 64'(old_hi));
    chk("flush_lo", 64'(lo), 64'(old_lo));

    // flush + start together in IDLE: op dropped.
    start = 1'b1; flush = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_drop", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of an op.
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_flags", 64'({busy, stall, done, dz}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
